// File: rtl/project1_top.sv
// DE10-Lite lab top: 640x480@60 Hz VGA test patterns from the 50 MHz clock,
// switches mirrored on the LEDs, and switch/frame values on the 7-segment displays.
module project1_top #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B
);

    localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
    localparam logic [9:0] H_SYNC_S = 10'(H_VIS + H_FP);
    localparam logic [9:0] H_SYNC_E = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
    localparam logic [9:0] V_SYNC_S = 10'(V_VIS + V_FP);
    localparam logic [9:0] V_SYNC_E = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [8:0] F_LAST   = 9'(V_VIS - 1);
    localparam logic [9:0] BAR_W    = 10'(H_VIS / 8);

    logic       w_rstN;
    logic       w_unused_keys;
    logic       r_pixEn;
    logic [9:0] r_hcnt;
    logic [9:0] r_vcnt;
    logic [8:0] r_frame;
    logic       r_hsN;
    logic       r_vsN;
    logic       r_blankN;
    logic [23:0] r_rgb;
    logic [9:0] r_led;
    logic [6:0] r_hex0, r_hex1, r_hex2, r_hex3, r_hex4, r_hex5;
    logic       w_visible;
    logic [9:0] w_barIdx;
    logic [9:0] w_barTop;
    logic [9:0] w_barEnd;
    logic [23:0] w_rgb;

    assign w_rstN        = KEY[0];
    assign w_unused_keys = &{1'b0, KEY[3:1]};

    function automatic logic [6:0] hexSeg(input logic [3:0] d);
        case (d)
            4'h0: hexSeg = 7'h40;
            4'h1: hexSeg = 7'h79;
            4'h2: hexSeg = 7'h24;
            4'h3: hexSeg = 7'h30;
            4'h4: hexSeg = 7'h19;
            4'h5: hexSeg = 7'h12;
            4'h6: hexSeg = 7'h02;
            4'h7: hexSeg = 7'h78;
            4'h8: hexSeg = 7'h00;
            4'h9: hexSeg = 7'h10;
            4'hA: hexSeg = 7'h08;
            4'hB: hexSeg = 7'h03;
            4'hC: hexSeg = 7'h46;
            4'hD: hexSeg = 7'h21;
            4'hE: hexSeg = 7'h06;
            default: hexSeg = 7'h0E;
        endcase
    endfunction

    // Counters step on every other clock; frame drives the moving bar.
    always_ff @(posedge CLOCK_50 or negedge w_rstN) begin
        if (!w_rstN) begin
            r_pixEn <= 1'b0;
            r_hcnt  <= 10'd0;
            r_vcnt  <= 10'd0;
            r_frame <= 9'd0;
        end else begin
            r_pixEn <= ~r_pixEn;
            if (r_pixEn) begin
                if (r_hcnt == H_LAST) begin
                    r_hcnt <= 10'd0;
                    if (r_vcnt == V_LAST) begin
                        r_vcnt  <= 10'd0;
                        r_frame <= (r_frame == F_LAST) ? 9'd0 : r_frame + 9'd1;
                    end else begin
                        r_vcnt <= r_vcnt + 10'd1;
                    end
                end else begin
                    r_hcnt <= r_hcnt + 10'd1;
                end
            end
        end
    end

    assign w_visible = (r_hcnt < H_VIS_C) && (r_vcnt < V_VIS_C);
    assign w_barIdx  = r_hcnt / BAR_W;
    assign w_barTop  = {1'b0, r_frame};
    assign w_barEnd  = w_barTop + 10'd16;

    always_comb begin
        w_rgb = 24'h000000;
        if (w_visible) begin
            case (SW[9:8])
                2'b00: begin
                    case (w_barIdx)
                        10'd0:   w_rgb = 24'hFFFFFF;
                        10'd1:   w_rgb = 24'hFFFF00;
                        10'd2:   w_rgb = 24'h00FFFF;
                        10'd3:   w_rgb = 24'h00FF00;
                        10'd4:   w_rgb = 24'hFF00FF;
                        10'd5:   w_rgb = 24'hFF0000;
                        10'd6:   w_rgb = 24'h0000FF;
                        default: w_rgb = 24'h000000;
                    endcase
                end
                2'b01: w_rgb = {SW[7:5], SW[7:5], SW[7:6],
                                SW[4:2], SW[4:2], SW[4:3],
                                {4{SW[1:0]}}};
                2'b10: w_rgb = (r_hcnt[5] ^ r_vcnt[5]) ? 24'h000000 : 24'hFFFFFF;
                default: w_rgb = ((r_vcnt >= w_barTop) && (r_vcnt < w_barEnd))
                                 ? 24'hFFFFFF : 24'h000040;
            endcase
        end
    end

    // Sync, blank and colour all lag the counters by exactly one pixel.
    always_ff @(posedge CLOCK_50 or negedge w_rstN) begin
        if (!w_rstN) begin
            r_hsN    <= 1'b1;
            r_vsN    <= 1'b1;
            r_blankN <= 1'b0;
            r_rgb    <= 24'h000000;
        end else if (r_pixEn) begin
            r_hsN    <= !((r_hcnt >= H_SYNC_S) && (r_hcnt <= H_SYNC_E));
            r_vsN    <= !((r_vcnt >= V_SYNC_S) && (r_vcnt <= V_SYNC_E));
            r_blankN <= w_visible;
            r_rgb    <= w_rgb;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge w_rstN) begin
        if (!w_rstN) begin
            r_led  <= 10'd0;
            r_hex0 <= 7'h40;
            r_hex1 <= 7'h40;
            r_hex2 <= 7'h40;
            r_hex3 <= 7'h40;
            r_hex4 <= 7'h40;
            r_hex5 <= 7'h7F;
        end else begin
            r_led  <= SW;
            r_hex0 <= hexSeg(SW[3:0]);
            r_hex1 <= hexSeg(SW[7:4]);
            r_hex2 <= hexSeg(r_frame[3:0]);
            r_hex3 <= hexSeg(r_frame[7:4]);
            r_hex4 <= hexSeg({2'b00, SW[9:8]});
            r_hex5 <= 7'h7F;
        end
    end

    assign LEDR        = r_led;
    assign HEX0        = r_hex0;
    assign HEX1        = r_hex1;
    assign HEX2        = r_hex2;
    assign HEX3        = r_hex3;
    assign HEX4        = r_hex4;
    assign HEX5        = r_hex5;
    assign VGA_CLK     = r_pixEn;
    assign VGA_HS      = r_hsN;
    assign VGA_VS      = r_vsN;
    assign VGA_BLANK_N = r_blankN;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_R       = r_rgb[23:16];
    assign VGA_G       = r_rgb[15:8];
    assign VGA_B       = r_rgb[7:0];

endmodule

// File: tb/tb_project1_top.sv
// Directed bench: a full-size instance for line timing and patterns, and a
// shrunken-timing instance so whole frames fit into a short run.
module tb_project1_top;

    logic       clk;
    logic [3:0] keyA, keyB;
    logic [9:0] swA, swB;
    logic [9:0] ledA, ledB;
    logic [6:0] hexA0, hexA1, hexA2, hexA3, hexA4, hexA5;
    logic [6:0] hexB0, hexB1, hexB2, hexB3, hexB4, hexB5;
    logic       vclkA, hsA, vsA, blankA, syncA;
    logic       vclkB, hsB, vsB, blankB, syncB;
    logic [7:0] rA, gA, bA, rB, gB, bB;

    int nChecks;
    int nErrors;
    int elapsed;

    project1_top dutA (
        .CLOCK_50(clk), .KEY(keyA), .SW(swA), .LEDR(ledA),
        .HEX0(hexA0), .HEX1(hexA1), .HEX2(hexA2), .HEX3(hexA3), .HEX4(hexA4), .HEX5(hexA5),
        .VGA_CLK(vclkA), .VGA_HS(hsA), .VGA_VS(vsA), .VGA_BLANK_N(blankA), .VGA_SYNC_N(syncA),
        .VGA_R(rA), .VGA_G(gA), .VGA_B(bA)
    );

    // 56 pixels x 48 lines: HS low on 44..51, VS low on 42..43, frame = 5376 clocks.
    project1_top #(
        .H_VIS(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_VIS(40), .V_FP(2), .V_SYNC(2), .V_BP(4)
    ) dutB (
        .CLOCK_50(clk), .KEY(keyB), .SW(swB), .LEDR(ledB),
        .HEX0(hexB0), .HEX1(hexB1), .HEX2(hexB2), .HEX3(hexB3), .HEX4(hexB4), .HEX5(hexB5),
        .VGA_CLK(vclkB), .VGA_HS(hsB), .VGA_VS(vsB), .VGA_BLANK_N(blankB), .VGA_SYNC_N(syncB),
        .VGA_R(rB), .VGA_G(gB), .VGA_B(bB)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (clock %0d)", tag, obs, exp, elapsed);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            elapsed++;
        end
    endtask

    // Pixel p of line L (full timing) is visible from clock L*1600 + 2p + 2 after release.
    task automatic advanceTo(input int target);
        while (elapsed < target) tick(1);
    endtask

    task automatic applyStimulus();
        // Full-size instance: reset state
        swA = 10'h000;
        swB = 10'h300;
        keyA = 4'b1111;
        keyB = 4'b1111;
        elapsed = 0;
        #5;
        keyA = 4'b1110;
        keyB = 4'b1110;
        repeat (30) @(negedge clk);
        checkOutput("rst HS", {31'b0, hsA}, 32'd1);
        checkOutput("rst VS", {31'b0, vsA}, 32'd1);
        checkOutput("rst BLANK_N", {31'b0, blankA}, 32'd0);
        checkOutput("rst RGB", {8'b0, rA, gA, bA}, 32'h0);
        checkOutput("rst VGA_CLK", {31'b0, vclkA}, 32'd0);
        checkOutput("rst LEDR", {22'b0, ledA}, 32'h0);
        checkOutput("rst HEX0", {25'b0, hexA0}, 32'h40);
        checkOutput("rst HEX5", {25'b0, hexA5}, 32'h7F);
        checkOutput("SYNC_N", {31'b0, syncA}, 32'd0);

        keyA = 4'b1111;
        elapsed = 0;
        tick(1);
        checkOutput("VGA_CLK hi", {31'b0, vclkA}, 32'd1);
        tick(1);
        checkOutput("VGA_CLK lo", {31'b0, vclkA}, 32'd0);
        checkOutput("bar px0", {8'b0, rA, gA, bA}, 32'hFFFFFF);
        checkOutput("blank px0", {31'b0, blankA}, 32'd1);
        checkOutput("HEX1:0 sw0", {18'b0, hexA1, hexA0}, {18'b0, 7'h40, 7'h40});
        checkOutput("HEX3:2 f0", {18'b0, hexA3, hexA2}, {18'b0, 7'h40, 7'h40});
        advanceTo(160);  checkOutput("bar px79", {8'b0, rA, gA, bA}, 32'hFFFFFF);
        advanceTo(162);  checkOutput("bar px80", {8'b0, rA, gA, bA}, 32'hFFFF00);
        advanceTo(320);  checkOutput("bar px159", {8'b0, rA, gA, bA}, 32'hFFFF00);
        advanceTo(802);  checkOutput("bar px400", {8'b0, rA, gA, bA}, 32'hFF0000);
        advanceTo(1122); checkOutput("bar px560", {8'b0, rA, gA, bA}, 32'h000000);
        checkOutput("blank px560", {31'b0, blankA}, 32'd1);
        advanceTo(1280); checkOutput("blank px639", {31'b0, blankA}, 32'd1);
        advanceTo(1282); checkOutput("blank px640", {31'b0, blankA}, 32'd0);
        checkOutput("rgb px640", {8'b0, rA, gA, bA}, 32'h0);
        advanceTo(1313); checkOutput("HS px655", {31'b0, hsA}, 32'd1);
        advanceTo(1314); checkOutput("HS px656", {31'b0, hsA}, 32'd0);
        advanceTo(1505); checkOutput("HS px751", {31'b0, hsA}, 32'd0);
        advanceTo(1506); checkOutput("HS px752", {31'b0, hsA}, 32'd1);
        advanceTo(2913); checkOutput("HS L1 px655", {31'b0, hsA}, 32'd1);
        advanceTo(2914); checkOutput("HS L1 px656", {31'b0, hsA}, 32'd0);
        checkOutput("VS line1", {31'b0, vsA}, 32'd1);

        // Solid colour from switches
        advanceTo(3000);
        swA = 10'b01_1110_0011;
        checkOutput("LEDR before", {22'b0, ledA}, 32'h0);
        tick(1);
        checkOutput("LEDR after", {22'b0, ledA}, 32'h1E3);
        checkOutput("HEX1 E", {25'b0, hexA1}, 32'h06);
        checkOutput("HEX0 3", {25'b0, hexA0}, 32'h30);
        checkOutput("HEX4 1", {25'b0, hexA4}, 32'h79);
        advanceTo(3402); checkOutput("solid L2 px100", {8'b0, rA, gA, bA}, 32'hFF00FF);
        advanceTo(4602); checkOutput("solid L2 px700", {8'b0, rA, gA, bA}, 32'h0);
        checkOutput("blank L2 px700", {31'b0, blankA}, 32'd0);

        // Mid-line reset while HS is low
        advanceTo(4700);
        checkOutput("HS pre-reset", {31'b0, hsA}, 32'd0);
        keyA = 4'b1110;
        #1;
        checkOutput("mid rst HS", {31'b0, hsA}, 32'd1);
        checkOutput("mid rst VS", {31'b0, vsA}, 32'd1);
        checkOutput("mid rst BLANK_N", {31'b0, blankA}, 32'd0);
        checkOutput("mid rst RGB", {8'b0, rA, gA, bA}, 32'h0);
        checkOutput("mid rst LEDR", {22'b0, ledA}, 32'h0);
        checkOutput("mid rst HEX1", {25'b0, hexA1}, 32'h40);
        repeat (5) @(negedge clk);
        swA = 10'h200;
        keyA = 4'b1111;
        elapsed = 0;
        advanceTo(64);   checkOutput("chk (31,0)", {8'b0, rA, gA, bA}, 32'hFFFFFF);
        advanceTo(66);   checkOutput("chk (32,0)", {8'b0, rA, gA, bA}, 32'h000000);
        checkOutput("blank (32,0)", {31'b0, blankA}, 32'd1);
        checkOutput("HEX4 2", {25'b0, hexA4}, 32'h24);
        advanceTo(1313); checkOutput("rel HS px655", {31'b0, hsA}, 32'd1);
        advanceTo(1314); checkOutput("rel HS px656", {31'b0, hsA}, 32'd0);

        // Shrunken instance: whole frames, moving bar, checkerboard at line 32
        @(negedge clk);
        keyB = 4'b1111;
        elapsed = 0;
        advanceTo(89);   checkOutput("B HS px43", {31'b0, hsB}, 32'd1);
        advanceTo(90);   checkOutput("B HS px44", {31'b0, hsB}, 32'd0);
        advanceTo(1692); checkOutput("B bar (5,15)", {8'b0, rB, gB, bB}, 32'hFFFFFF);
        advanceTo(1804); checkOutput("B bar (5,16)", {8'b0, rB, gB, bB}, 32'h000040);
        advanceTo(1900);
        swB = 10'h200;
        advanceTo(3648); checkOutput("B chk (31,32)", {8'b0, rB, gB, bB}, 32'h000000);
        advanceTo(3650); checkOutput("B chk (32,32)", {8'b0, rB, gB, bB}, 32'hFFFFFF);
        advanceTo(3700);
        swB = 10'h300;
        advanceTo(4705); checkOutput("B VS L41", {31'b0, vsB}, 32'd1);
        advanceTo(4706); checkOutput("B VS L42", {31'b0, vsB}, 32'd0);
        advanceTo(4929); checkOutput("B VS L43", {31'b0, vsB}, 32'd0);
        advanceTo(4930); checkOutput("B VS L44", {31'b0, vsB}, 32'd1);
        advanceTo(5370); checkOutput("B HEX2 f0", {25'b0, hexB2}, 32'h40);
        advanceTo(5380); checkOutput("B HEX2 f1", {25'b0, hexB2}, 32'h79);
        checkOutput("B HEX3 f1", {25'b0, hexB3}, 32'h40);
        advanceTo(5388); checkOutput("B f1 bar (5,0)", {8'b0, rB, gB, bB}, 32'h000040);
        advanceTo(7180); checkOutput("B f1 bar (5,16)", {8'b0, rB, gB, bB}, 32'hFFFFFF);
        advanceTo(7292); checkOutput("B f1 bar (5,17)", {8'b0, rB, gB, bB}, 32'h000040);
        advanceTo(10760); checkOutput("B HEX2 f2", {25'b0, hexB2}, 32'h24);
    endtask

    initial begin
        nChecks = 0;
        nErrors = 0;
        applyStimulus();
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
